instr_fetch_unit: RTL



---
 rtl/instr_fetch_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Decoupled RV32I fetch stage: sequential req/gnt/rvalid fetch into a DEPTH-entry FIFO,
// flushed and restarted on redirect. Define IFU_ALIGN_CHK_EN to fault and halt on misaligned redirects.
module instr_fetch_unit #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

  state_t           state_q, state_nxt;
  logic [31:0]      fetch_pc_q, fetch_pc_nxt;
  logic [31:0]      req_pc_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_nxt;
  logic [31:0]      fifo_instr [DEPTH];
  logic [31:0]      fifo_pc    [DEPTH];
  logic             granted, push, pop, fault_nxt, can_req;
`ifdef IFU_ALIGN_CHK_EN
  logic             fault_q;
`endif

  // Shared control terms; can_req looks at the occupancy after this cycle's push/pop/flush
  always_comb begin
    granted = (state_q == S_REQ) && mem_gnt;
    push    = (state_q == S_WAIT) && mem_rvalid && !redirect;
    pop     = (count_q != '0) && instr_ready && !redirect;
    if (redirect) count_nxt = '0;
    else          count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);
`ifdef IFU_ALIGN_CHK_EN
    fault_nxt = fault_q || (redirect && (redirect_pc[1:0] != 2'b00));
`else
    fault_nxt = 1'b0;
`endif
    can_req = (count_nxt < DEPTH_C) && !fault_nxt;
    if (redirect)     fetch_pc_nxt = redirect_pc & 32'hFFFF_FFFC;
    else if (granted) fetch_pc_nxt = fetch_pc_q + 32'd4;
    else              fetch_pc_nxt = fetch_pc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_nxt;
  end

  // A redirect that leaves a granted request unanswered goes to DROP to swallow its response
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: if (can_req) state_nxt = S_REQ;
      S_REQ: begin
        if (redirect)     state_nxt = mem_gnt ? S_DROP : S_IDLE;
        else if (mem_gnt) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid)    state_nxt = can_req ? S_REQ : S_IDLE;
        else if (redirect) state_nxt = S_DROP;
      end
      S_DROP: if (mem_rvalid) state_nxt = can_req ? S_REQ : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
`ifdef IFU_ALIGN_CHK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      fetch_pc_q <= fetch_pc_nxt;
      count_q    <= count_nxt;
      if (redirect) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
`ifdef IFU_ALIGN_CHK_EN
      fault_q    <= fault_nxt;
`endif
    end
  end

  // FIFO storage and the address of the in-flight request carry no reset
  always_ff @(posedge clk) begin
    if (granted) req_pc_q <= fetch_pc_q;
    if (push) begin
      fifo_instr[wr_ptr_q] <= mem_rdata;
      fifo_pc[wr_ptr_q]    <= req_pc_q;
    end
  end

  always_comb begin
    mem_req     = (state_q == S_REQ);
    mem_addr    = fetch_pc_q;
    instr_valid = (count_q != '0);
    instr       = instr_valid ? fifo_instr[rd_ptr_q] : NOP_INSTR;
    instr_pc    = instr_valid ? fifo_pc[rd_ptr_q] : 32'h0000_0000;
`ifdef IFU_ALIGN_CHK_EN
    fetch_fault = fault_q;
`else
    fetch_fault = 1'b0;
`endif
  end

endmodule
